// File: rtl/seq_mult_4x4.sv
// -----------------------------------------------------------------------------
// seq_mult_4x4 -- sequential 4x4 unsigned shift-and-add multiplier.
//
// Computes an 8-bit product in four add/shift steps, using one four_bit_rca
// instance as the datapath adder. A start/busy/done handshake lets a parent
// issue operand pairs and collect registered products.
//
// Ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset
//   start in   1  request a multiplication (honoured only in IDLE)
//   A     in   4  multiplicand, captured on the accepting edge
//   B     in   4  multiplier, captured on the accepting edge
//   P     out  8  registered product, held until the next completion
//   busy  out  1  high while in RUN
//   done  out  1  one-cycle pulse, high in DONE
// -----------------------------------------------------------------------------

// four_bit_rca -- 4-bit ripple-carry adder.
// Ports: A/B in 4 addends, Cin in 1 carry-in, S out 4 sum, Cout out 1 carry-out.
module four_bit_rca (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

module seq_mult_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [3:0] acc_q,   acc_d;
  logic [3:0] q_q,     q_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [7:0] p_q,     p_d;

  logic [3:0] sum;
  logic       cout;

  // Adder always sees the upper partial product and the multiplicand; the
  // step logic decides whether to take its result based on q[0].
  four_bit_rca u_rca (
    .A    (acc_q),
    .B    (mcand_q),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would infer a latch.
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = A;
          q_d     = B;
          acc_d   = 4'd0;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Carry shifts into acc[3], so the 9-bit intermediate is never lost.
        if (q_q[0]) {acc_d, q_d} = {cout, sum, q_q[3:1]};
        else        {acc_d, q_d} = {1'b0, acc_q, q_q[3:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          // Fourth step: publish the freshly shifted result on the same edge.
          p_d     = {acc_d, q_d};
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= 4'd0;
      acc_q   <= 4'd0;
      q_q     <= 4'd0;
      cnt_q   <= 3'd0;
      p_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign P    = p_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
